edge_event_arbiter: RTL

- Collects single-cycle `rise` pulses from up to N_CH edge detectors and queues one pending event per channel.
- Serialises the pending events to a single downstream consumer over a valid/ready handshake, using round-robin arbitration.
- Sits between the bank of edge detectors and the event consumer (interrupt/sequencer logic).
- Flags lost events (overrun) per channel.

---
 rtl/edge_evt_pkg.sv | 16 +
 rtl/edge_event_arbiter_rr_pick.sv | 37 +++
 rtl/edge_event_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/edge_evt_pkg.sv
// Shared types and sizing helpers for the edge event arbiter.
package edge_evt_pkg;

  localparam int N_CH_DEF = 4;
  localparam int TS_W_DEF = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after last_i, wrapping; purely combinational.
module rr_pick
  import edge_evt_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int ID_W = id_w(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [ID_W-1:0] last_i,
  output logic [ID_W-1:0] idx_o,
  output logic            found_o
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [ID_W:0]     sh;
  int                ch;

  // rot[k] is the request of channel (last_i + 1 + k) mod N_CH
  always_comb begin
    sh      = {1'b0, last_i} + (ID_W + 1)'(1);
    dbl     = {req_i, req_i} >> sh;
    rot     = dbl[N_CH-1:0];
    idx_o   = '0;
    found_o = 1'b0;
    ch      = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found_o && rot[k]) begin
        found_o = 1'b1;
        ch      = int'(last_i) + 1 + k;
        if (ch >= N_CH) ch = ch - N_CH;
        idx_o   = ID_W'(ch);
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Queues one pending event per channel and serialises them round-robin over valid/ready; rise->valid 2 cycles min,
// back-to-back grants while ready is high, holds ev_ch while stalled. Optional ev_ts via EDGE_EVT_TIMESTAMP_EN.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
`ifdef EDGE_EVT_TIMESTAMP_EN
  , parameter int TS_W = TS_W_DEF
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         rise_in,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [id_w(N_CH)-1:0]   ev_ch,
  output logic [N_CH-1:0]         pending,
  output logic [N_CH-1:0]         overrun,
  input  logic [N_CH-1:0]         ovr_clr
`ifdef EDGE_EVT_TIMESTAMP_EN
  , output logic [TS_W-1:0]       ev_ts
`endif
);

  localparam int ID_W = id_w(N_CH);

  state_e          state_q, state_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] ovr_q, ovr_d;
  logic [N_CH-1:0] gnt_mask;
  logic [ID_W-1:0] ch_q, ch_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] pick_idx;
  logic            pick_found;
  logic            grant;

  rr_pick #(
    .N_CH (N_CH),
    .ID_W (ID_W)
  ) u_pick (
    .req_i   (pend_q),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // In PRESENT a new grant only happens on the handshake edge
  assign grant    = pick_found && ((state_q == IDLE) || ev_ready);
  assign gnt_mask = grant ? (N_CH'(1) << pick_idx) : '0;

  always_comb begin
    pend_d = (pend_q & ~gnt_mask) | rise_in;
    ovr_d  = (ovr_q & ~ovr_clr) | (rise_in & pend_q & ~gnt_mask);
    ch_d   = grant ? pick_idx : ch_q;
    last_d = grant ? pick_idx : last_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovr_q   <= '0;
      ch_q    <= '0;
      last_q  <= ID_W'(N_CH - 1);
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = PRESENT;
      PRESENT: if (ev_ready && !pick_found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ev_valid = (state_q == PRESENT);
    ev_ch    = ch_q;
    pending  = pend_q;
    overrun  = ovr_q;
  end

`ifdef EDGE_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] cnt_q;
  logic [TS_W-1:0] ts_out_q;
  logic [TS_W-1:0] ts_q [N_CH];

  // A stamp is taken only when pending goes 0->1, so the oldest event time survives overruns
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      ts_out_q <= '0;
      for (int i = 0; i < N_CH; i++) ts_q[i] <= '0;
    end else begin
      cnt_q <= cnt_q + TS_W'(1);
      for (int i = 0; i < N_CH; i++) begin
        if (rise_in[i] && !pend_q[i]) ts_q[i] <= cnt_q;
      end
      if (grant) ts_out_q <= ts_q[pick_idx];
    end
  end

  assign ev_ts = ts_out_q;
`endif

endmodule
